// File: rtl/gameover_ctrl_if.sv
`timescale 1ns/1ps
// Signal bundle between game logic and the game-over controller.
// The game side (master) drives deaths, frame ticks and the button; the controller (slave) drives overlay state.
interface gameover_ctrl_if;
  logic       frame_tick;
  logic       p1_dead;
  logic       p2_dead;
  logic       restart_btn;
  logic [1:0] winner_latched;
  logic       overlay_en;
  logic       game_reset;
  logic       game_over;

  modport master (
    output frame_tick, p1_dead, p2_dead, restart_btn,
    input  winner_latched, overlay_en, game_reset, game_over
  );

  modport slave (
    input  frame_tick, p1_dead, p2_dead, restart_btn,
    output winner_latched, overlay_en, game_reset, game_over
  );
endinterface

// File: rtl/gameover_ctrl.sv
`timescale 1ns/1ps
// End-of-round sequencer: settles near-simultaneous deaths into a winner, holds and blinks the overlay,
// then turns a fresh restart press into a one-cycle game reset.
module gameover_ctrl #(
  parameter int SETTLE_FRAMES = 4,
  parameter int HOLD_FRAMES   = 120,
  parameter int BLINK_FRAMES  = 30,
  parameter int CNT_W         = 8
) (
  input logic           clk,
  input logic           rst,
  gameover_ctrl_if.slave bus
);

  typedef enum logic [1:0] {PLAY, SETTLE, SHOW, RESTART} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             d1, d1_nx, d2, d2_nx;
  logic             hold_done, hold_nx;
  logic             btn_prev;
  logic [1:0]       winner_q, winner_nx;
  logic             overlay_q, overlay_nx;
  logic             game_reset_q, game_reset_nx;
  logic             game_over_q;
  logic             btn_edge;
  logic             d1_seen, d2_seen;

  assign btn_edge = bus.restart_btn & ~btn_prev;
  assign d1_seen  = d1 | bus.p1_dead;
  assign d2_seen  = d2 | bus.p2_dead;

  assign bus.winner_latched = winner_q;
  assign bus.overlay_en     = overlay_q;
  assign bus.game_reset     = game_reset_q;
  assign bus.game_over      = game_over_q;

  // All outputs come straight from flops; btn_prev resets high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= PLAY;
      cnt          <= '0;
      d1           <= 1'b0;
      d2           <= 1'b0;
      hold_done    <= 1'b0;
      btn_prev     <= 1'b1;
      winner_q     <= 2'b00;
      overlay_q    <= 1'b0;
      game_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      d1           <= d1_nx;
      d2           <= d2_nx;
      hold_done    <= hold_nx;
      btn_prev     <= bus.restart_btn;
      winner_q     <= winner_nx;
      overlay_q    <= overlay_nx;
      game_reset_q <= game_reset_nx;
      game_over_q  <= (state_nx != PLAY);
    end
  end

  // The counter saturates by default and is cleared whenever a phase ends (including hold -> blink).
  always_comb begin
    state_nx      = state;
    cnt_nx        = (bus.frame_tick && cnt != '1) ? cnt + 1'b1 : cnt;
    d1_nx         = d1;
    d2_nx         = d2;
    hold_nx       = hold_done;
    winner_nx     = winner_q;
    overlay_nx    = overlay_q;
    game_reset_nx = 1'b0;

    case (state)
      PLAY: begin
        winner_nx  = 2'b00;
        overlay_nx = 1'b0;
        hold_nx    = 1'b0;
        if (bus.p1_dead || bus.p2_dead) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
          d1_nx    = d1_seen;
          d2_nx    = d2_seen;
        end
      end

      SETTLE: begin
        d1_nx = d1_seen;
        d2_nx = d2_seen;
        // {d1,d2} is directly the winner code: only P2 dead -> 01 (P1 wins), both -> draw.
        if (bus.frame_tick && cnt == SETTLE_LAST) begin
          state_nx   = SHOW;
          cnt_nx     = '0;
          hold_nx    = 1'b0;
          overlay_nx = 1'b1;
          winner_nx  = {d1_seen, d2_seen};
        end
      end

      SHOW: begin
        if (btn_edge && hold_done) begin
          state_nx      = RESTART;
          cnt_nx        = '0;
          hold_nx       = 1'b0;
          overlay_nx    = 1'b0;
          winner_nx     = 2'b00;
          d1_nx         = 1'b0;
          d2_nx         = 1'b0;
          game_reset_nx = 1'b1;
        end else if (bus.frame_tick) begin
          if (!hold_done) begin
            if (cnt == HOLD_LAST) begin
              hold_nx = 1'b1;
              cnt_nx  = '0;
            end
          end else if (cnt == BLINK_LAST) begin
            overlay_nx = ~overlay_q;
            cnt_nx     = '0;
          end
        end
      end

      RESTART: begin
        state_nx = PLAY;
        cnt_nx   = '0;
        d1_nx    = 1'b0;
        d2_nx    = 1'b0;
      end

      default: begin
        state_nx = PLAY;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gameover_ctrl.sv
`timescale 1ns/1ps
// Bench for gameover_ctrl: directed round scenarios with literal checks, then randomized play,
// all compared every cycle against a frame-counting model of the round.
module tb_gameover_ctrl;
  localparam int SETTLE_FRAMES = 4;
  localparam int HOLD_FRAMES   = 120;
  localparam int BLINK_FRAMES  = 30;
  localparam int CNT_W         = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_on = 1'b0;
  logic r1, r2, rb;

  gameover_ctrl_if bus();

  gameover_ctrl #(
    .SETTLE_FRAMES(SETTLE_FRAMES),
    .HOLD_FRAMES  (HOLD_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: phase 0 playing, 1 settling, 2 showing, 3 restarting; m_ticks counts frames within the phase.
  int         m_phase = 0;
  int         m_ticks = 0;
  bit         m_s1 = 1'b0;
  bit         m_s2 = 1'b0;
  logic [1:0] m_winner = 2'b00;
  bit         m_btn_prev = 1'b1;
  bit         m_press;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase    = 0;
      m_ticks    = 0;
      m_s1       = 1'b0;
      m_s2       = 1'b0;
      m_winner   = 2'b00;
      m_btn_prev = 1'b1;
    end else begin
      m_press    = bus.restart_btn && !m_btn_prev;
      m_btn_prev = bus.restart_btn;
      case (m_phase)
        0: if (bus.p1_dead || bus.p2_dead) begin
             m_phase = 1;
             m_ticks = 0;
             m_s1    = bus.p1_dead;
             m_s2    = bus.p2_dead;
           end
        1: begin
             m_s1 = m_s1 | bus.p1_dead;
             m_s2 = m_s2 | bus.p2_dead;
             if (bus.frame_tick) m_ticks++;
             if (m_ticks == SETTLE_FRAMES) begin
               m_winner = (m_s1 && m_s2) ? 2'b11 : (m_s2 ? 2'b01 : 2'b10);
               m_phase  = 2;
               m_ticks  = 0;
             end
           end
        2: if (m_press && m_ticks >= HOLD_FRAMES) m_phase = 3;
           else if (bus.frame_tick) m_ticks++;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    logic ov;
    if (cmp_on) begin
      if (m_phase != 2)                  ov = 1'b0;
      else if (m_ticks <= HOLD_FRAMES)   ov = 1'b1;
      else ov = (((m_ticks - HOLD_FRAMES) / BLINK_FRAMES) % 2) == 0;
      checkOutput("game_over",      {1'b0, bus.game_over},  (m_phase != 0) ? 2'd1 : 2'd0);
      checkOutput("game_reset",     {1'b0, bus.game_reset}, (m_phase == 3) ? 2'd1 : 2'd0);
      checkOutput("winner_latched", bus.winner_latched,     (m_phase == 2) ? m_winner : 2'b00);
      checkOutput("overlay_en",     {1'b0, bus.overlay_en}, {1'b0, ov});
    end
  end

  task automatic applyStimulus(input logic a1, input logic a2, input logic tk, input logic bt);
    @(negedge clk);
    #1;
    bus.p1_dead     = a1;
    bus.p2_dead     = a2;
    bus.frame_tick  = tk;
    bus.restart_btn = bt;
  endtask

  task automatic runFrames(input int n, input logic a1, input logic a2, input logic bt);
    repeat (n) begin
      applyStimulus(a1, a2, 1'b1, bt);
      repeat (3) applyStimulus(a1, a2, 1'b0, bt);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.p1_dead = 1'b0; bus.p2_dead = 1'b0; bus.frame_tick = 1'b0; bus.restart_btn = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    checkOutput("reset_game_over", {1'b0, bus.game_over}, 2'd0);
    checkOutput("reset_overlay",   {1'b0, bus.overlay_en}, 2'd0);
    checkOutput("reset_winner",    bus.winner_latched, 2'b00);
    #1 rst = 1'b1;

    // P2 dies for a single cycle: P1 wins on the 4th tick, restart only after the hold.
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("go_one_clk_after_death", {1'b0, bus.game_over}, 2'd1);
    runFrames(3, 0, 0, 0);
    checkOutput("winner_before_4th_tick", bus.winner_latched, 2'b00);
    runFrames(1, 0, 0, 0);
    checkOutput("winner_at_4th_tick", bus.winner_latched, 2'b01);
    checkOutput("overlay_on_show", {1'b0, bus.overlay_en}, 2'd1);
    runFrames(50, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("early_press_ignored", {1'b0, bus.game_reset}, 2'd0);
    runFrames(71, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("restart_pulse", {1'b0, bus.game_reset}, 2'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("restart_pulse_one_cycle", {1'b0, bus.game_reset}, 2'd0);
    checkOutput("play_after_restart", {1'b0, bus.game_over}, 2'd0);

    // P1 dies, P2 two frames later inside the settle window: draw.
    applyStimulus(1, 0, 0, 0);
    runFrames(2, 1, 0, 0);
    runFrames(2, 1, 1, 0);
    checkOutput("draw_winner", bus.winner_latched, 2'b11);
    runFrames(HOLD_FRAMES, 1, 1, 0);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("draw_restart", {1'b0, bus.game_reset}, 2'd1);
    applyStimulus(0, 0, 0, 0);

    // P2 dies after the window closes: P2 wins; then observe the blink cadence.
    applyStimulus(1, 0, 0, 0);
    runFrames(4, 1, 0, 0);
    runFrames(1, 1, 1, 0);
    checkOutput("late_p2_winner", bus.winner_latched, 2'b10);
    runFrames(HOLD_FRAMES - 1 + 29, 1, 1, 0);
    checkOutput("blink_before_first_toggle", {1'b0, bus.overlay_en}, 2'd1);
    runFrames(1, 1, 1, 0);
    checkOutput("blink_first_toggle", {1'b0, bus.overlay_en}, 2'd0);
    runFrames(30, 1, 1, 0);
    checkOutput("blink_second_toggle", {1'b0, bus.overlay_en}, 2'd1);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Button held from before the round ends never restarts; a fresh press does.
    applyStimulus(0, 1, 0, 1);
    runFrames(4 + 200, 0, 1, 1);
    checkOutput("held_btn_no_restart", {1'b0, bus.game_over}, 2'd1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("fresh_press_restart", {1'b0, bus.game_reset}, 2'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fresh_press_single", {1'b0, bus.game_reset}, 2'd0);

    // Asynchronous reset in the middle of the overlay.
    applyStimulus(1, 1, 0, 0);
    runFrames(14, 1, 1, 0);
    checkOutput("overlay_before_async_rst", {1'b0, bus.overlay_en}, 2'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    bus.p1_dead = 1'b0;
    bus.p2_dead = 1'b0;
    #1;
    checkOutput("async_rst_overlay", {1'b0, bus.overlay_en}, 2'd0);
    checkOutput("async_rst_game_over", {1'b0, bus.game_over}, 2'd0);
    checkOutput("async_rst_winner", bus.winner_latched, 2'b00);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("no_pulse_after_rst", {1'b0, bus.game_reset}, 2'd0);

    // Randomized play: deaths stick until game_reset (mostly), button toggles, occasional reset.
    r1 = 1'b0; r2 = 1'b0; rb = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if (bus.game_reset && $urandom_range(0, 3) != 0) begin r1 = 1'b0; r2 = 1'b0; end
      if (!r1 && $urandom_range(0, 59) == 0) r1 = 1'b1;
      if (!r2 && $urandom_range(0, 59) == 0) r2 = 1'b1;
      if ($urandom_range(0, 24) == 0) rb = ~rb;
      if ($urandom_range(0, 2999) == 0) begin
        @(posedge clk);
        #3 rst = 1'b0;
        r1 = 1'b0; r2 = 1'b0;
        bus.p1_dead = 1'b0; bus.p2_dead = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
      end
      applyStimulus(r1, r2, 1'($urandom_range(0, 1)), rb);
    end

    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
